// File: rtl/sdr_16_responder.sv
// SDR SDRAM target model for the 16-bit controller: command decode, bank/row tracking,
// burst engine with CAS-latency read pipeline. Define SDR_RESP_CL3_EN to accept CL=3.
module sdr_16_responder #(
    parameter int ba_size  = 2,
    parameter int row_size = 13,
    parameter int col_size = 9,
    parameter int mem_aw   = 10
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst_n,
    input  logic [ba_size-1:0]  ba,
    input  logic [row_size-1:0] a,
    input  logic [2:0]          cmd,
    input  logic [15:0]         dq_i,
    input  logic                dq_oe,
    output logic [15:0]         dq_o,
    output logic                dq_o_valid,
    output logic [3:0]          bank_open,
    output logic [2:0]          cl_o,
    output logic [2:0]          bl_o,
    output logic [15:0]         refresh_cnt,
    output logic [2:0]          err,
    input  logic                err_clr
);

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PCH = 3'b010;
    localparam logic [2:0] CMD_RFR = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_BURST = 2'd3;

`ifdef SDR_RESP_CL3_EN
    localparam int PIPE = 3;
`else
    localparam int PIPE = 2;
`endif

    logic [15:0]         mem      [0:(1<<mem_aw)-1];
    logic [row_size-1:0] open_row [0:3];

    logic [1:0]          state;
    logic [2:0]          beat, bst_last;
    logic [ba_size-1:0]  bst_ba;
    logic [row_size-1:0] bst_row;
    logic [col_size-1:0] bst_col;
    logic                bst_zero, bst_cl3;

    logic [PIPE-1:0]     p_v, p_zero, p_cl3;
    logic [mem_aw-1:0]   p_idx [0:PIPE-1];

    logic                is_rd, is_wr, sel_open, cur_cl3, cl_ok, bl_ok;
    logic                iss_v, iss_zero, iss_cl3, wr_en, o_v, o_zero;
    logic [2:0]          cur_lenm1, err_set;
    logic [mem_aw-1:0]   cmd_idx, bst_idx, iss_idx, wr_idx, o_idx;

    // Column advances by k and wraps inside the BL-aligned block.
    function automatic logic [mem_aw-1:0] beat_idx(
        input logic [ba_size-1:0]  b,
        input logic [row_size-1:0] r,
        input logic [col_size-1:0] c,
        input logic [2:0]          k,
        input logic [2:0]          lenm1
    );
        logic [col_size-1:0] m, cw;
        m  = col_size'(lenm1);
        cw = (c & ~m) | ((c + col_size'(k)) & m);
        return mem_aw'({b, r, cw});
    endfunction

    always_comb begin
        is_rd    = (cmd == CMD_RD);
        is_wr    = (cmd == CMD_WR);
        sel_open = bank_open[ba];
        case (bl_o)
            3'b001:  cur_lenm1 = 3'd1;
            3'b010:  cur_lenm1 = 3'd3;
            3'b011:  cur_lenm1 = 3'd7;
            default: cur_lenm1 = 3'd0;
        endcase
`ifdef SDR_RESP_CL3_EN
        cur_cl3 = (cl_o == 3'b011);
        cl_ok   = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
`else
        cur_cl3 = 1'b0;
        cl_ok   = (a[6:4] == 3'b010);
`endif
        bl_ok = !a[2];

        err_set    = '0;
        err_set[0] = (is_rd || is_wr) && !sel_open;
        err_set[1] = (cmd == CMD_ACT) && sel_open;
        err_set[2] = ((cmd == CMD_LMR) && !(cl_ok && bl_ok)) || (is_wr && sel_open && !dq_oe);

        cmd_idx = beat_idx(ba, open_row[ba], a[col_size-1:0], 3'd0, cur_lenm1);
        bst_idx = beat_idx(bst_ba, bst_row, bst_col, beat, bst_last);

        iss_v    = 1'b0;
        iss_zero = 1'b0;
        iss_cl3  = 1'b0;
        iss_idx  = cmd_idx;
        if (is_rd) begin
            iss_v    = 1'b1;
            iss_zero = !sel_open;
            iss_cl3  = cur_cl3;
        end else if (state == RD_BURST) begin
            iss_v    = 1'b1;
            iss_zero = bst_zero;
            iss_cl3  = bst_cl3;
            iss_idx  = bst_idx;
        end

        wr_en  = is_wr ? (sel_open && dq_oe) : ((state == WR_BURST) && dq_oe);
        wr_idx = is_wr ? cmd_idx : bst_idx;

        // A CL=2 beat overtakes an older CL=3 beat landing on the same edge.
        o_v    = 1'b0;
        o_idx  = p_idx[1];
        o_zero = p_zero[1];
        if (p_v[1] && !p_cl3[1]) begin
            o_v = 1'b1;
        end else if (p_v[PIPE-1] && p_cl3[PIPE-1]) begin
            o_v    = 1'b1;
            o_idx  = p_idx[PIPE-1];
            o_zero = p_zero[PIPE-1];
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (wr_en)
            mem[wr_idx] <= dq_i;
        if (cmd == CMD_ACT)
            open_row[ba] <= a;
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            bst_last    <= '0;
            bst_ba      <= '0;
            bst_row     <= '0;
            bst_col     <= '0;
            bst_zero    <= 1'b0;
            bst_cl3     <= 1'b0;
            p_v         <= '0;
            p_zero      <= '0;
            p_cl3       <= '0;
            for (int unsigned i = 0; i < PIPE; i++)
                p_idx[i] <= '0;
            dq_o        <= '0;
            dq_o_valid  <= 1'b0;
            bank_open   <= '0;
            cl_o        <= 3'b010;
            bl_o        <= 3'b001;
            refresh_cnt <= '0;
            err         <= '0;
        end else begin
            if (is_rd || is_wr) begin
                bst_ba   <= ba;
                bst_row  <= open_row[ba];
                bst_col  <= a[col_size-1:0];
                bst_last <= cur_lenm1;
                bst_zero <= !sel_open;
                bst_cl3  <= cur_cl3;
                beat     <= 3'd1;
                if (is_wr && !sel_open)
                    state <= IDLE;
                else if (cur_lenm1 == 3'd0)
                    state <= is_rd ? RD_WAIT : IDLE;
                else
                    state <= is_rd ? RD_BURST : WR_BURST;
            end else begin
                case (state)
                    WR_BURST, RD_BURST: begin
                        beat <= beat + 3'd1;
                        if (beat == bst_last)
                            state <= (state == RD_BURST) ? RD_WAIT : IDLE;
                    end
                    RD_WAIT: if (p_v == '0) state <= IDLE;
                    default: ;
                endcase
            end

            p_v      <= {p_v[PIPE-2:0], iss_v};
            p_zero   <= {p_zero[PIPE-2:0], iss_zero};
            p_cl3    <= {p_cl3[PIPE-2:0], iss_cl3};
            p_idx[0] <= iss_idx;
            for (int unsigned i = 1; i < PIPE; i++)
                p_idx[i] <= p_idx[i-1];

            case (cmd)
                CMD_ACT: bank_open[ba] <= 1'b1;
                CMD_PCH: begin
                    if (a[10])
                        bank_open <= '0;
                    else
                        bank_open[ba] <= 1'b0;
                end
                CMD_RFR: refresh_cnt <= refresh_cnt + 16'd1;
                CMD_LMR: begin
                    cl_o <= cl_ok ? a[6:4] : 3'b010;
                    bl_o <= bl_ok ? a[2:0] : 3'b000;
                end
                default: ;
            endcase

            err        <= (err_clr ? 3'b000 : err) | err_set;
            dq_o_valid <= o_v;
            if (o_v)
                dq_o <= o_zero ? 16'h0000 : mem[o_idx];
        end
    end

endmodule

// File: tb/tb_sdr_16_responder.sv
// Directed bench for sdr_16_responder; expectations follow SDR_RESP_CL3_EN when defined.
module tb_sdr_16_responder;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PCH = 3'b010;
    localparam logic [2:0] RFR = 3'b001;
    localparam logic [2:0] LMR = 3'b000;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst_n = 1'b0;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic [2:0]  cmd = NOP;
    logic [15:0] dq_i = '0;
    logic        dq_oe = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] dq_o;
    logic        dq_o_valid;
    logic [3:0]  bank_open;
    logic [2:0]  cl_o, bl_o, err;
    logic [15:0] refresh_cnt;

    int checks = 0;
    int errors = 0;

    sdr_16_responder dut (
        .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .ba(ba), .a(a), .cmd(cmd),
        .dq_i(dq_i), .dq_oe(dq_oe), .dq_o(dq_o), .dq_o_valid(dq_o_valid),
        .bank_open(bank_open), .cl_o(cl_o), .bl_o(bl_o), .refresh_cnt(refresh_cnt),
        .err(err), .err_clr(err_clr)
    );

    always #5 sdram_clk = ~sdram_clk;

    // Drives one command for one rising edge, then samples 1 ns after that edge.
    task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                        input logic [15:0] d, input logic oe);
        cmd = c; ba = b; a = addr; dq_i = d; dq_oe = oe;
        @(posedge sdram_clk);
        #1;
        cmd = NOP; dq_oe = 1'b0;
    endtask

    task automatic nop();
        step(NOP, 2'd0, 13'h0, 16'h0, 1'b0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        nop();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sdram_clk);
        #1;
        checks++; if (dq_o !== 16'h0) begin errors++; $display("FAIL rst_dq got %h want 0000", dq_o); end
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", dq_o_valid); end
        checks++; if (bank_open !== 4'b0) begin errors++; $display("FAIL rst_bank got %b want 0000", bank_open); end
        checks++; if (cl_o !== 3'b010 || bl_o !== 3'b001) begin errors++; $display("FAIL rst_mode got cl=%b bl=%b want 010 001", cl_o, bl_o); end
        checks++; if (refresh_cnt !== 16'h0 || err !== 3'b0) begin errors++; $display("FAIL rst_cnt_err got %h %b want 0000 000", refresh_cnt, err); end
        sdram_rst_n = 1'b1;
    endtask

    task automatic test_init();
        step(PCH, 2'd0, 13'h0400, 16'h0, 1'b0);
        step(RFR, 2'd0, 13'h0, 16'h0, 1'b0);
        step(RFR, 2'd0, 13'h0, 16'h0, 1'b0);
        step(LMR, 2'd0, 13'h0021, 16'h0, 1'b0);
        checks++; if (cl_o !== 3'd2 || bl_o !== 3'd1) begin errors++; $display("FAIL init_mode got cl=%0d bl=%0d want 2 1", cl_o, bl_o); end
        checks++; if (refresh_cnt !== 16'd2) begin errors++; $display("FAIL init_refresh got %0d want 2", refresh_cnt); end
        checks++; if (err !== 3'b0) begin errors++; $display("FAIL init_err got %b want 000", err); end
    endtask

    task automatic test_bl2_rw();
        logic [15:0] exp [2] = '{16'hA5A5, 16'h5A5A};
        step(ACT, 2'd1, 13'd5, 16'h0, 1'b0);
        checks++; if (bank_open !== 4'b0010) begin errors++; $display("FAIL bl2_act got %b want 0010", bank_open); end
        step(WR, 2'd1, 13'd2, 16'hA5A5, 1'b1);
        step(NOP, 2'd0, 13'd0, 16'h5A5A, 1'b1);
        step(RD, 2'd1, 13'd2, 16'h0, 1'b0);
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL bl2_early got valid %b want 0", dq_o_valid); end
        for (int i = 0; i < 2; i++) begin
            nop();
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== exp[i]) begin
                errors++; $display("FAIL bl2_beat%0d got %b/%h want 1/%h", i, dq_o_valid, dq_o, exp[i]);
            end
        end
        nop();
        checks++; if (dq_o_valid !== 1'b0 || dq_o !== 16'h5A5A) begin errors++; $display("FAIL bl2_hold got %b/%h want 0/5a5a", dq_o_valid, dq_o); end
        checks++; if (err !== 3'b0) begin errors++; $display("FAIL bl2_err got %b want 000", err); end
    endtask

    task automatic test_bl4_wrap();
        logic [15:0] wd  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [15:0] exp [4] = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
        step(LMR, 2'd0, 13'h0022, 16'h0, 1'b0);
        checks++; if (bl_o !== 3'b010) begin errors++; $display("FAIL bl4_mode got %b want 010", bl_o); end
        step(WR, 2'd1, 13'd4, wd[0], 1'b1);
        for (int i = 1; i < 4; i++) step(NOP, 2'd0, 13'd0, wd[i], 1'b1);
        step(RD, 2'd1, 13'd6, 16'h0, 1'b0);
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL bl4_early got valid %b want 0", dq_o_valid); end
        for (int i = 0; i < 4; i++) begin
            nop();
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== exp[i]) begin
                errors++; $display("FAIL bl4_beat%0d got %b/%h want 1/%h", i, dq_o_valid, dq_o, exp[i]);
            end
        end
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL bl4_end got valid %b want 0", dq_o_valid); end
    endtask

    task automatic test_errors();
        step(ACT, 2'd0, 13'd7, 16'h0, 1'b0);
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_act1 got %b want 000", err); end
        step(ACT, 2'd0, 13'd9, 16'h0, 1'b0);
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL err_act2 got %b want 010", err); end
        clear_err();
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_clr got %b want 000", err); end
        err_clr = 1'b1;
        step(ACT, 2'd0, 13'd3, 16'h0, 1'b0);
        err_clr = 1'b0;
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL err_clr_same got %b want 010", err); end
        clear_err();
        step(RD, 2'd3, 13'd0, 16'h0, 1'b0);
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL err_closed got %b want 001", err); end
        checks++; if (bank_open !== 4'b0011) begin errors++; $display("FAIL err_banks got %b want 0011", bank_open); end
        nop();
        for (int i = 0; i < 4; i++) begin
            nop();
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== 16'h0000) begin
                errors++; $display("FAIL closed_beat%0d got %b/%h want 1/0000", i, dq_o_valid, dq_o);
            end
        end
        clear_err();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4] = '{16'hA5A5, 16'h5A5A, 16'h1111, 16'h2222};
        step(LMR, 2'd0, 13'h0021, 16'h0, 1'b0);
        step(RD, 2'd1, 13'd2, 16'h0, 1'b0);
        nop();
        step(RD, 2'd1, 13'd4, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== exp[i]) begin
                errors++; $display("FAIL b2b_beat%0d got %b/%h want 1/%h", i, dq_o_valid, dq_o, exp[i]);
            end
            nop();
        end
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got valid %b want 0", dq_o_valid); end
    endtask

    task automatic test_cl3();
        logic [15:0] exp [2] = '{16'hA5A5, 16'h5A5A};
        step(LMR, 2'd0, 13'h0031, 16'h0, 1'b0);
`ifdef SDR_RESP_CL3_EN
        checks++; if (cl_o !== 3'd3 || err !== 3'b000) begin errors++; $display("FAIL cl3_mode got cl=%0d err=%b want 3 000", cl_o, err); end
`else
        checks++; if (cl_o !== 3'd2 || err !== 3'b100) begin errors++; $display("FAIL cl3_mode got cl=%0d err=%b want 2 100", cl_o, err); end
`endif
        clear_err();
        step(RD, 2'd1, 13'd2, 16'h0, 1'b0);
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL cl3_t1 got valid %b want 0", dq_o_valid); end
`ifdef SDR_RESP_CL3_EN
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL cl3_t2 got valid %b want 0", dq_o_valid); end
`endif
        for (int i = 0; i < 2; i++) begin
            nop();
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== exp[i]) begin
                errors++; $display("FAIL cl3_beat%0d got %b/%h want 1/%h", i, dq_o_valid, dq_o, exp[i]);
            end
        end
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL cl3_end got valid %b want 0", dq_o_valid); end
    endtask

    task automatic test_raw();
        step(LMR, 2'd0, 13'h0020, 16'h0, 1'b0);
        step(WR, 2'd1, 13'd8, 16'hCAFE, 1'b1);
        step(WR, 2'd1, 13'd8, 16'hBEEF, 1'b1);
        step(RD, 2'd1, 13'd8, 16'h0, 1'b0);
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL raw_early got valid %b want 0", dq_o_valid); end
        nop();
        checks++; if (dq_o_valid !== 1'b1 || dq_o !== 16'hBEEF) begin errors++; $display("FAIL raw_data got %b/%h want 1/beef", dq_o_valid, dq_o); end
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL raw_end got valid %b want 0", dq_o_valid); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp [2] = '{16'hA5A5, 16'h5A5A};
        step(LMR, 2'd0, 13'h0021, 16'h0, 1'b0);
        step(RD, 2'd1, 13'd2, 16'h0, 1'b0);
        nop();
        nop();
        checks++; if (dq_o_valid !== 1'b1 || dq_o !== 16'hA5A5) begin errors++; $display("FAIL rmid_pre got %b/%h want 1/a5a5", dq_o_valid, dq_o); end
        sdram_rst_n = 1'b0;
        #1;
        checks++; if (dq_o_valid !== 1'b0 || dq_o !== 16'h0) begin errors++; $display("FAIL rmid_out got %b/%h want 0/0000", dq_o_valid, dq_o); end
        checks++; if (bank_open !== 4'b0 || cl_o !== 3'd2 || bl_o !== 3'd1) begin errors++; $display("FAIL rmid_state got %b cl=%0d bl=%0d want 0000 2 1", bank_open, cl_o, bl_o); end
        #1;
        sdram_rst_n = 1'b1;
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain got valid %b want 0", dq_o_valid); end
        step(ACT, 2'd1, 13'd5, 16'h0, 1'b0);
        step(RD, 2'd1, 13'd2, 16'h0, 1'b0);
        nop();
        checks++; if (dq_o_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got valid %b want 0", dq_o_valid); end
        for (int i = 0; i < 2; i++) begin
            nop();
            checks++;
            if (dq_o_valid !== 1'b1 || dq_o !== exp[i]) begin
                errors++; $display("FAIL rmid_beat%0d got %b/%h want 1/%h", i, dq_o_valid, dq_o, exp[i]);
            end
        end
        checks++; if (err !== 3'b0) begin errors++; $display("FAIL rmid_err got %b want 000", err); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_bl2_rw();
        test_bl4_wrap();
        test_errors();
        test_back_to_back();
        test_cl3();
        test_raw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
